// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Boot-time program loader. Receives a framed byte stream
//                (16-bit word count, little-endian payload words, XOR
//                checksum), writes the words sequentially into instruction
//                memory and holds the core in reset until the image is
//                loaded and verified.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // Largest legal word count, evaluated at 17 bits so 2^16 is representable.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_n_lo;       // low count byte, held until the high byte arrives
    logic [15:0] r_n_words;    // word count N of the current frame
    logic [15:0] r_word_idx;   // index of the word currently being assembled
    logic [1:0]  r_byte_cnt;   // byte position within the current word
    logic [23:0] r_word_sr;    // first three bytes of the current word
    logic [7:0]  r_chk;        // running XOR of payload bytes

    logic        w_accept;
    logic [15:0] w_n_full;
    logic        w_n_bad;
    logic [31:0] w_word;
    logic        w_last_word;

    // Ready is a pure state decode: no backpressure while writing.
    assign byte_ready  = (r_state == HDR_LO) || (r_state == HDR_HI) ||
                         (r_state == DATA)   || (r_state == CHK);
    assign w_accept    = byte_valid & byte_ready;
    assign w_n_full    = {byte_data, r_n_lo};
    assign w_n_bad     = (w_n_full == 16'd0) || ({1'b0, w_n_full} > MAX_WORDS);
    // Incoming byte completes the word in bits 31:24 (little-endian order).
    assign w_word      = {byte_data, r_word_sr};
    assign w_last_word = (r_word_idx == (r_n_words - 16'd1));

    // Frame-parsing FSM with registered memory-write and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= HDR_LO;
            r_n_lo     <= 8'd0;
            r_n_words  <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word_sr  <= 24'd0;
            r_chk      <= 8'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    HDR_LO: begin
                        r_n_lo  <= byte_data;
                        r_state <= HDR_HI;
                    end
                    HDR_HI: begin
                        r_n_words <= w_n_full;
                        if (w_n_bad) begin
                            error   <= 1'b1;
                            r_state <= ERROR;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_chk      <= r_chk ^ byte_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_word_sr  <= {byte_data, r_word_sr[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= {14'd0, r_word_idx, 2'b00};
                            imem_wdata <= w_word;
                            r_word_idx <= r_word_idx + 16'd1;
                            if (w_last_word) begin
                                r_state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        if (byte_data == r_chk) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            r_state   <= DONE;
                        end else begin
                            error   <= 1'b1;
                            r_state <= ERROR;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Expected memory writes
//                are derived from the transmitted frame and queued; a monitor
//                pops and compares them whenever imem_we is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clock;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  tx[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    prog_loader #(.ADDR_WIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                check("wr_addr", imem_addr, exp_addr.pop_front());
                check("wr_data", imem_wdata, exp_data.pop_front());
            end
        end
    end

    // Present one byte after an idle gap filled with garbage data.
    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_data = 8'($urandom);
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    // Send tx[], queuing expected writes from an independent frame model.
    task automatic run_frame(input int max_gap, input int stall_idx);
        int          n;
        int          k;
        logic [31:0] w;
        n = {tx[1], tx[0]};
        w = 32'd0;
        for (int i = 0; i < tx.size(); i++) begin
            if (i == stall_idx) begin
                send_byte_stall();
            end
            if (i >= 2 && i < 2 + 4 * n) begin
                k = i - 2;
                w[8 * (k % 4) +: 8] = tx[i];
                if (k % 4 == 3) begin
                    exp_addr.push_back(32'(k / 4) * 32'd4);
                    exp_data.push_back(w);
                end
            end
            if (i == tx.size() - 1 && i >= 2 + 4 * n) begin
                check("cpu_reset_pre_chk", {31'd0, cpu_reset}, 32'd1);
                check("done_pre_chk", {31'd0, done}, 32'd0);
            end
            send_byte(tx[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    // Idle cycles with valid low and changing data; nothing may be absorbed.
    task automatic send_byte_stall();
        byte_valid = 1'b0;
        repeat (3) begin
            byte_data = 8'hFF ^ 8'($urandom);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_done_state(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_error_state(input string tag);
        @(negedge clock);
        check({tag, "_error"}, {31'd0, error}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        #12;
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // N=1 single word
        tx = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        run_frame(0, -1);
        check_done_state("n1");

        // N=2 with random gaps
        apply_reset();
        tx = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00, 8'h41};
        run_frame(3, -1);
        check_done_state("n2");

        // Zero word count
        apply_reset();
        tx = '{8'h00, 8'h00};
        run_frame(0, -1);
        check_error_state("n0");

        // Word count 257 exceeds 2^8
        apply_reset();
        tx = '{8'h01, 8'h01};
        run_frame(0, -1);
        check_error_state("n257");

        // Word count 256 is the maximum legal size: loader must stay in DATA
        apply_reset();
        tx = '{8'h00, 8'h01};
        run_frame(0, -1);
        check("n256_error", {31'd0, error}, 32'd0);
        check("n256_ready", {31'd0, byte_ready}, 32'd1);

        // Bad checksum: write still lands, then error
        apply_reset();
        tx = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h00};
        run_frame(0, -1);
        check_error_state("badchk");
        // A fresh frame after the error must be ignored
        tx = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], 0);
        check_error_state("post_err");

        // Reset in the middle of a word
        apply_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, imem_we}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        check("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("mid_rst_ready", {31'd0, byte_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tx = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        run_frame(0, -1);
        check_done_state("after_rst");

        // Idle garbage with valid low in the middle of a word
        apply_reset();
        tx = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00, 8'h41};
        run_frame(1, 4);
        check_done_state("stall");

        repeat (3) @(posedge clock);
        #1;
        check("final_sb_empty", 32'(exp_addr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
